// File: rtl/crc_sched_pkg.sv
// crc_sched_pkg: shared types and frame sizing for the CRC checker scheduler
package crc_sched_pkg;

   typedef enum logic [2:0] {IDLE, STREAM, WAIT_RES, RESULT, ABORT} state_t;

   typedef logic req_id_t;

   typedef struct packed {
      logic    val;
      req_id_t id;
      logic    err;
      logic    abort;
   } stat_t;

   function automatic int frame_len(input int num_bits);
      return num_bits + 16;
   endfunction

   localparam int NUM_BITS_DEF = 1904;
   localparam int FRAME_LEN    = NUM_BITS_DEF + 16;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on contention grants the requester not served last
module rr_arb2
   import crc_sched_pkg::*;
(
   input  logic [1:0] req_i,
   input  req_id_t    last_i,
   output logic [1:0] gnt_o,
   output req_id_t    id_o,
   output logic       vld_o
);

   always_comb begin
      vld_o = |req_i;
      id_o  = &req_i ? ~last_i : req_i[1];
      gnt_o = vld_o ? (id_o ? 2'b10 : 2'b01) : 2'b00;
   end

endmodule

// File: rtl/crc_chk_sched.sv
// crc_chk_sched: shares one bit-serial CRC-16 checker between two requesters, frame by frame.
// Optional CRC_SCHED_STAT_CNT_EN adds saturating per-requester frame/error counters.
module crc_chk_sched
   import crc_sched_pkg::*;
#(
   parameter int NUM_BITS    = NUM_BITS_DEF,
   parameter int STALL_MAX   = 255,
   parameter int RES_TIMEOUT = 15,
   parameter int FLUSH_CYC   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  ival,
   input  logic [1:0]  data_in,
   output logic [1:0]  gnt,
   output logic        chk_ival,
   output logic        chk_data,
   output logic        chk_rst_n,
   input  logic        chk_err_val,
   input  logic        chk_errors,
   output logic        stat_val,
   output logic        stat_id,
   output logic        stat_err,
   output logic        stat_abort
`ifdef CRC_SCHED_STAT_CNT_EN
   ,
   output logic [15:0] frm_cnt0,
   output logic [15:0] frm_cnt1,
   output logic [15:0] err_cnt0,
   output logic [15:0] err_cnt1
`endif
);

   localparam int FLEN = frame_len(NUM_BITS);
   localparam int SW   = $clog2(STALL_MAX + 1);
   localparam int TW   = $clog2(RES_TIMEOUT + 1);
   localparam int FW   = $clog2(FLUSH_CYC + 1);

   state_t        state_q, state_d;
   logic [1:0]    gnt_q, gnt_d;
   req_id_t       cur_q, cur_d, last_q, last_d;
   logic [11:0]   bit_q, bit_d;
   logic [SW-1:0] stall_q, stall_d;
   logic [TW-1:0] wait_q, wait_d;
   logic [FW-1:0] flush_q, flush_d;
   logic          ival_q, data_q, hold_q;
   logic [1:0]    arb_gnt;
   req_id_t       arb_id;
   logic          arb_vld;
   logic          acc, last_bit;
   stat_t         stat;

   rr_arb2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (arb_gnt),
      .id_o   (arb_id),
      .vld_o  (arb_vld)
   );

   always_comb begin
      acc      = (state_q == STREAM) && ival[cur_q];
      last_bit = acc && (bit_q == 12'(FLEN - 1));
      state_d  = state_q;
      gnt_d    = '0;
      cur_d    = cur_q;
      last_d   = last_q;
      bit_d    = bit_q;
      stall_d  = stall_q;
      wait_d   = '0;
      flush_d  = '0;
      stat     = '0;
      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               state_d = STREAM;
               gnt_d   = arb_gnt;
               cur_d   = arb_id;
               bit_d   = '0;
               stall_d = '0;
            end
         end
         STREAM: begin
            gnt_d   = gnt_q;
            bit_d   = acc ? bit_q + 12'd1 : bit_q;
            stall_d = acc ? '0 : stall_q + SW'(1);
            // completion outranks a request drop on the final bit
            if (last_bit) begin
               state_d = WAIT_RES;
               gnt_d   = '0;
            end else if (!req[cur_q] || (!acc && stall_d == SW'(STALL_MAX))) begin
               state_d = ABORT;
               gnt_d   = '0;
            end
         end
         WAIT_RES: begin
            wait_d  = wait_q + TW'(1);
            state_d = chk_err_val ? RESULT : (wait_d == TW'(RES_TIMEOUT)) ? ABORT : WAIT_RES;
         end
         RESULT: begin
            stat    = stat_t'{val: 1'b1, id: cur_q, err: chk_errors, abort: 1'b0};
            last_d  = cur_q;
            state_d = IDLE;
         end
         ABORT: begin
            flush_d = flush_q + FW'(1);
            stat    = (flush_q == '0) ? stat_t'{val: 1'b1, id: cur_q, err: 1'b1, abort: 1'b1} : '0;
            if (flush_d == FW'(FLUSH_CYC)) begin
               state_d = IDLE;
               last_d  = cur_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         cur_q   <= 1'b0;
         last_q  <= 1'b1;
         bit_q   <= '0;
         stall_q <= '0;
         wait_q  <= '0;
         flush_q <= '0;
         ival_q  <= 1'b0;
         data_q  <= 1'b0;
         hold_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         bit_q   <= bit_d;
         stall_q <= stall_d;
         wait_q  <= wait_d;
         flush_q <= flush_d;
         ival_q  <= acc;
         data_q  <= acc & data_in[cur_q];
         hold_q  <= 1'b0;
      end
   end

   assign gnt        = gnt_q;
   assign chk_ival   = ival_q;
   assign chk_data   = data_q;
   assign chk_rst_n  = !(rst || hold_q || state_q == ABORT);
   assign stat_val   = stat.val & ~rst;
   assign stat_id    = stat.id;
   assign stat_err   = stat.err;
   assign stat_abort = stat.abort;

`ifdef CRC_SCHED_STAT_CNT_EN
   logic [1:0][15:0] frm_q, err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frm_q <= '0;
         err_q <= '0;
      end else if (stat.val) begin
         frm_q[stat.id] <= frm_q[stat.id] + 16'(~&frm_q[stat.id]);
         if (stat.err) err_q[stat.id] <= err_q[stat.id] + 16'(~&err_q[stat.id]);
      end
   end

   assign frm_cnt0 = frm_q[0];
   assign frm_cnt1 = frm_q[1];
   assign err_cnt0 = err_q[0];
   assign err_cnt1 = err_q[1];
`endif

endmodule

// File: tb/tb_crc_chk_sched.sv
// tb_crc_chk_sched: directed bench for crc_chk_sched with a bit-serial CRC-16 checker model
module tb_crc_chk_sched;
   import crc_sched_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = '0, ival = '0, data_in = '0;
   logic [1:0] gnt;
   logic       chk_ival, chk_data, chk_rst_n;
   logic       chk_err_val = 1'b0, chk_errors = 1'b0;
   logic       stat_val, stat_id, stat_err, stat_abort;
`ifdef CRC_SCHED_STAT_CNT_EN
   logic [15:0] frm_cnt0, frm_cnt1, err_cnt0, err_cnt1;
`endif

   int          checks = 0, errors = 0;
   logic        frame [FRAME_LEN];
   logic [15:0] m_crc = '0;
   int          m_cnt = 0;
   bit          withhold = 1'b0;
   int          stat_n = 0, ival_n = 0, rstn_low = 0, both_gnt = 0;
   int          n, n0;

   crc_chk_sched dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .ival        (ival),
      .data_in     (data_in),
      .gnt         (gnt),
      .chk_ival    (chk_ival),
      .chk_data    (chk_data),
      .chk_rst_n   (chk_rst_n),
      .chk_err_val (chk_err_val),
      .chk_errors  (chk_errors),
      .stat_val    (stat_val),
      .stat_id     (stat_id),
      .stat_err    (stat_err),
      .stat_abort  (stat_abort)
`ifdef CRC_SCHED_STAT_CNT_EN
      ,
      .frm_cnt0    (frm_cnt0),
      .frm_cnt1    (frm_cnt1),
      .err_cnt0    (err_cnt0),
      .err_cnt1    (err_cnt1)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   // checker: CRC-16/0x1021 over data+crc, zero remainder means clean
   always begin
      @(posedge clk);
      #1;
      chk_err_val = 1'b0;
      if (!chk_rst_n) begin
         m_crc = '0;
         m_cnt = 0;
      end else if (chk_ival) begin
         m_crc = crc_step(m_crc, chk_data);
         m_cnt++;
         if (m_cnt == FRAME_LEN) begin
            chk_err_val = !withhold;
            chk_errors  = (m_crc != 16'h0000);
            m_crc = '0;
            m_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (stat_val) stat_n++;
      if (chk_ival) ival_n++;
      if (!chk_rst_n) rstn_low++;
      if (gnt == 2'b11) both_gnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic build_frame();
      logic [15:0] c = '0;
      for (int k = 0; k < NUM_BITS_DEF; k++) begin
         frame[k] = 1'($urandom);
         c = crc_step(c, frame[k]);
      end
      for (int k = 0; k < 16; k++) frame[NUM_BITS_DEF + k] = c[15 - k];
   endtask

   task automatic send(input int id, input int nbits, input int flip, input int drop_at,
                       input bit keep, input string tag);
      int w = 0;
      build_frame();
      req[id] = 1'b1;
      while (!gnt[id] && w < 64) begin
         tick();
         w++;
      end
      chk({tag, " grant"}, 32'(gnt[id]), 32'd1);
      chk({tag, " idle_chk_ival"}, 32'(chk_ival), 32'd0);
      for (int k = 0; k < nbits; k++) begin
         ival[id]    = 1'b1;
         data_in[id] = frame[k] ^ (k == flip);
         if (k == drop_at) req[id] = 1'b0;
         tick();
         if (k == 0) begin
            chk({tag, " first_chk_ival"}, 32'(chk_ival), 32'd1);
            chk({tag, " first_chk_data"}, 32'(chk_data), 32'(data_in[id]));
         end
      end
      ival[id]    = 1'b0;
      data_in[id] = 1'b0;
      if (!keep) req[id] = 1'b0;
   endtask

   task automatic wait_stat(input int max, output int cnt);
      cnt = 0;
      while (!stat_val && cnt < max) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      tick();
      tick();
      tick();
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst chk_ival", 32'(chk_ival), 32'd0);
      chk("rst stat_val", 32'(stat_val), 32'd0);
      chk("rst chk_rst_n", 32'(chk_rst_n), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_rel chk_rst_n", 32'(chk_rst_n), 32'd0);
      tick();
      chk("rst_rel+1 chk_rst_n", 32'(chk_rst_n), 32'd1);

      ival_n = 0;
      send(0, FRAME_LEN, -1, -1, 1'b0, "integ");
      chk("integ gnt_drop", 32'(gnt), 32'd0);
      wait_stat(20, n);
      chk("integ stat_lat", 32'(n), 32'd1);
      chk("integ stat_id", 32'(stat_id), 32'd0);
      chk("integ stat_err", 32'(stat_err), 32'd0);
      chk("integ stat_abort", 32'(stat_abort), 32'd0);
      tick();
      chk("integ ival_cnt", 32'(ival_n), 32'(FRAME_LEN));

      rst = 1'b1;
      tick();
      tick();
      rst      = 1'b0;
      req      = 2'b11;
      both_gnt = 0;
      tick();
      chk("arb first_gnt", 32'(gnt), 32'd1);
      send(0, FRAME_LEN, 10, -1, 1'b0, "arb0");
      wait_stat(20, n);
      chk("arb0 stat_id", 32'(stat_id), 32'd0);
      chk("arb0 stat_err", 32'(stat_err), 32'd1);
      chk("arb0 stat_abort", 32'(stat_abort), 32'd0);
      send(1, FRAME_LEN, 1500, -1, 1'b0, "arb1");
      wait_stat(20, n);
      chk("arb1 stat_id", 32'(stat_id), 32'd1);
      chk("arb1 stat_err", 32'(stat_err), 32'd1);
      chk("arb1 stat_abort", 32'(stat_abort), 32'd0);
      chk("arb both_gnt", 32'(both_gnt), 32'd0);
      tick();

      send(1, 100, -1, -1, 1'b1, "stall");
      rstn_low = 0;
      wait_stat(400, n);
      chk("stall idle_cycles", 32'(n), 32'd255);
      chk("stall stat_id", 32'(stat_id), 32'd1);
      chk("stall stat_err", 32'(stat_err), 32'd1);
      chk("stall stat_abort", 32'(stat_abort), 32'd1);
      send(1, FRAME_LEN, -1, -1, 1'b0, "stall_retry");
      wait_stat(20, n);
      chk("stall_retry stat_id", 32'(stat_id), 32'd1);
      chk("stall_retry stat_err", 32'(stat_err), 32'd0);
      chk("stall_retry stat_abort", 32'(stat_abort), 32'd0);
      chk("stall flush_cycles", 32'(rstn_low), 32'd2);
      tick();

      send(0, 301, -1, 300, 1'b0, "drop_mid");
      wait_stat(20, n);
      chk("drop_mid stat_lat", 32'(n), 32'd0);
      chk("drop_mid stat_abort", 32'(stat_abort), 32'd1);
      chk("drop_mid stat_err", 32'(stat_err), 32'd1);
      tick();
      send(0, FRAME_LEN, -1, FRAME_LEN - 1, 1'b0, "drop_last");
      wait_stat(20, n);
      chk("drop_last stat_lat", 32'(n), 32'd1);
      chk("drop_last stat_err", 32'(stat_err), 32'd0);
      chk("drop_last stat_abort", 32'(stat_abort), 32'd0);
      tick();

      withhold = 1'b1;
      send(0, FRAME_LEN, -1, -1, 1'b0, "tmo");
      wait_stat(40, n);
      withhold = 1'b0;
      chk("tmo wait_cycles", 32'(n), 32'd15);
      chk("tmo stat_id", 32'(stat_id), 32'd0);
      chk("tmo stat_err", 32'(stat_err), 32'd1);
      chk("tmo stat_abort", 32'(stat_abort), 32'd1);
      tick();
      tick();
      tick();

      send(0, 500, -1, -1, 1'b1, "mrst");
      n0     = stat_n;
      rst    = 1'b1;
      req[0] = 1'b0;
      #1;
      chk("mrst chk_rst_n_in_rst", 32'(chk_rst_n), 32'd0);
      tick();
      chk("mrst gnt", 32'(gnt), 32'd0);
      chk("mrst chk_ival", 32'(chk_ival), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("mrst chk_rst_n_rel", 32'(chk_rst_n), 32'd0);
      tick();
      chk("mrst chk_rst_n_rel+1", 32'(chk_rst_n), 32'd1);
      tick();
      tick();
      chk("mrst no_stat", 32'(stat_n), 32'(n0));
      chk("mrst gnt_after", 32'(gnt), 32'd0);
`ifdef CRC_SCHED_STAT_CNT_EN
      chk("mrst frm_cnt0", 32'(frm_cnt0), 32'd0);
      chk("mrst frm_cnt1", 32'(frm_cnt1), 32'd0);
      chk("mrst err_cnt0", 32'(err_cnt0), 32'd0);
      chk("mrst err_cnt1", 32'(err_cnt1), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_chk_sched.md
Name: crc_chk_sched

Overview:
- Frame-granular scheduler that shares one bit-serial CRC-16 checker between two requesters (FEC decoder lanes 0/1).
- Grants the checker round-robin, forwards one frame of NUM_BITS data + 16 CRC bits, and collects the checker's verdict.
- Aborts stalled or abandoned frames by flushing the checker, and returns per-frame status.

Parameters:
- NUM_BITS, 1904, data bits per frame (frame length FRAME_LEN = NUM_BITS+16).
- STALL_MAX, 255, max consecutive idle cycles (no valid bit) while streaming before abort.
- RES_TIMEOUT, 15, max cycles waiting for checker verdict before abort.
- FLUSH_CYC, 2, cycles chk_rst_n is held low on abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  2  per-requester frame request; held high for the whole frame
- ival  in  2  per-requester bit valid
- data_in  in  2  per-requester serial bit
- gnt  out  2  one-hot grant, registered
- chk_ival  out  1  bit valid to checker
- chk_data  out  1  bit to checker
- chk_rst_n  out  1  active-low checker reset/flush
- chk_err_val  in  1  checker verdict strobe, coincident with the final bit
- chk_errors  in  1  checker CRC-fail flag, valid only the cycle after chk_err_val
- stat_val  out  1  one-cycle status pulse
- stat_id  out  1  requester the status refers to
- stat_err  out  1  1 = CRC fail or abort
- stat_abort  out  1  1 = frame aborted

Behaviour:
- Reset: all outputs 0 except chk_rst_n, which is driven 0 while rst=1 and for 1 cycle after release. FSM goes to IDLE. RR pointer favours requester 0.
- FSM states: IDLE, STREAM, WAIT_RES, RESULT, ABORT.
- IDLE:
  - If any req is high, arbitrate and go to STREAM; gnt is set on that transition.
  - If both are requesting, grant the one not served last. A single requester is granted regardless of the pointer.
- STREAM:
  - A bit is accepted when gnt[i] & ival[i].
  - chk_ival/chk_data are registered copies of the accepted bit (1-cycle latency). chk_ival=0 otherwise.
  - A 12-bit counter counts accepted bits. On accepting bit FRAME_LEN-1, clear gnt next cycle and go to WAIT_RES.
  - Stall counter clears on every accepted bit and increments otherwise. Reaching STALL_MAX goes to ABORT.
  - req[i] falling while streaming goes to ABORT, except in the cycle the last bit is accepted, where completion wins.
  - The ungranted requester's ival/data_in are ignored.
- WAIT_RES:
  - chk_err_val may arrive in the same cycle the last bit is presented on chk_ival, or later.
  - On chk_err_val go to RESULT.
  - After RES_TIMEOUT cycles without it, go to ABORT.
  - A chk_err_val seen outside STREAM/WAIT_RES is ignored.
- RESULT (1 cycle): sample chk_errors; pulse stat_val with stat_id, stat_err=chk_errors, stat_abort=0. Update the RR pointer and go to IDLE.
- ABORT:
  - Clear gnt and drive chk_rst_n=0 for FLUSH_CYC cycles.
  - On the first ABORT cycle, pulse stat_val with stat_err=1, stat_abort=1.
  - Update the RR pointer, then go to IDLE.
- gnt is never asserted outside STREAM. At most one gnt bit is ever high.
- rst mid-frame: immediate return to IDLE, gnt=0, no status pulse, checker flushed.

Optional Feature:
- Macro CRC_SCHED_STAT_CNT_EN.
- Defined: adds outputs frm_cnt0/frm_cnt1 and err_cnt0/err_cnt1 (16 bits each, saturating at 0xFFFF), cleared by rst.
  - frm_cnt increments on every stat_val for that id.
  - err_cnt increments when stat_err=1.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package crc_sched_pkg holds:
  - state_t enum
  - FRAME_LEN localparam function of NUM_BITS
  - req_id_t (1-bit)
  - stat_t struct {val, id, err, abort}
- One sub-module: rr_arb2, a 2-way round-robin arbiter with last-served pointer input and grant/id outputs.

Test Plan:
- Frame integrity: req0 alone, 1920 contiguous bits with good CRC. Expected:
  - 1920 chk_ival pulses, starting 1 cycle after the first accept.
  - gnt0 drops after bit 1919.
  - stat_val pulse with id=0, err=0, abort=0.
- Arbitration: req0 and req1 high together from reset, each sending a frame with a flipped data bit. Expected:
  - Order is 0 then 1.
  - Two stat pulses, both err=1.
  - gnt never 2'b11.
- Stall: requester 1 halts ival after 100 bits. Expected:
  - ABORT after 255 idle cycles.
  - chk_rst_n low 2 cycles.
  - stat id=1, err=1, abort=1.
  - The next frame on 1 checks clean.
- Drop timing: req0 drops mid-frame, then (separately) in the cycle the last bit is accepted. Expected:
  - Mid-frame drop aborts.
  - Last-bit drop gives a normal result.
- Verdict timeout: checker model withholds chk_err_val. Expected: abort after 15 cycles in WAIT_RES.
- Reset mid-frame: rst at bit 500. Expected:
  - No stat pulse, gnt=0.
  - chk_rst_n low during rst plus 1 cycle.
  - With CRC_SCHED_STAT_CNT_EN defined, counters read 0.
